// File: rtl/div_iter_param.sv
// Iterative restoring divider (DIV/DIVU) for the EX stage, radix 2^BITS_PER_CYCLE.
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   signed_div_i    1 = signed divide, 0 = unsigned (sampled at start)
//   start_i         level request, held high until the result is consumed
//   annul_i         flush; aborts an operation in CALC/FIX
//   opdata1_i       dividend (sampled at start)
//   opdata2_i       divisor  (sampled at start)
//   result_o        {remainder, quotient}
//   ready_o         result valid
//   busy_o          operation in progress (CALC or FIX)
//   div_zero_o      result came from a divide-by-zero (valid with ready_o)
module div_iter_param #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     step_rem, step_quo;
    logic [WIDTH:0]       trial;

    // Operand magnitudes at start; MIN stays MIN, which reads correctly as unsigned.
    always_comb begin
        a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (ZERO - opdata1_i) : opdata1_i;
        b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (ZERO - opdata2_i) : opdata2_i;
    end

    // One CALC cycle: BITS_PER_CYCLE restoring steps, quotient shifted in MSB first.
    // quo_q doubles as the dividend shift register feeding the partial remainder.
    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            trial    = {step_rem, step_quo[WIDTH-1]};
            step_quo = {step_quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvsr_q}) begin
                trial       = trial - {1'b0, dvsr_q};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[WIDTH-1:0];
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        dz_d       = dz_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        result_d   = result_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;
        busy_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    sign_d  = signed_div_i;
                    neg_a_d = signed_div_i & opdata1_i[WIDTH-1];
                    neg_b_d = signed_div_i & opdata2_i[WIDTH-1];
                    dvsr_d  = b_mag;
                    cnt_d   = '0;
                    if (opdata2_i == ZERO) begin
                        // Defined divide-by-zero result: raw dividend, all-ones quotient.
                        dz_d    = 1'b1;
                        rem_d   = opdata1_i;
                        quo_d   = '1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    // Remainder follows the dividend sign; MIN/-1 wraps back to MIN.
                    if (sign_q && (neg_a_q ^ neg_b_q)) quo_d = ZERO - quo_q;
                    if (sign_q && neg_a_q)             rem_d = ZERO - rem_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_d    = IDLE;
                    result_d   = '0;
                    ready_d    = 1'b0;
                    div_zero_d = 1'b0;
                end else begin
                    result_d   = {rem_q, quo_q};
                    ready_d    = 1'b1;
                    div_zero_d = dz_q;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            dz_q       <= 1'b0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            dz_q       <= dz_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param at WIDTH=32; BPC selects the radix.
module tb_div_iter_param #(
    parameter int unsigned BPC = 1
);
    localparam int LAT = 32 / BPC + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        busy;
    logic        div_zero;

    div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(BPC)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .start_i      (start),
        .annul_i      (annul),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
        .div_zero_o   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
        int          sc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest expected result.
    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("latency", 64'(cyc - e.sc), 64'(e.lat));
            end
        end
        ready_prev = ready;
    end

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {1'b0, r, q};
    endfunction

    // Issue one operation, scramble inputs after the start edge, consume, release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_res, input logic exp_dz, input bit chk_busy);
        exp_t e;
        int   k;
        int   lat;
        bit   got;
        lat = exp_dz ? 1 : LAT;
        @(negedge clk);
        op1 = a; op2 = b; signed_div = s; start = 1'b1;
        e.res = exp_res; e.dz = exp_dz; e.lat = lat; e.sc = cyc + 1;
        exp_q.push_back(e);
        got = 1'b0;
        for (int n = 0; n < lat + 6; n++) begin
            @(negedge clk);
            k = cyc - e.sc;
            if (n == 0) begin
                op1 = $urandom; op2 = $urandom; signed_div = ~s;
            end
            if (chk_busy && (k == 0 || k == lat - 2 || k == lat - 1))
                check($sformatf("busy_k%0d", k), 64'(busy), 64'(!exp_dz && k <= lat - 2));
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_timeout", 64'(ready), 64'd1);
        repeat (2) @(negedge clk);
        check("result_held", result, exp_res);
        start = 1'b0;
        @(negedge clk);
        check("release", {result[61:0], ready, div_zero}, 64'd0);
    endtask

    initial begin
        logic [64:0] m;
        logic [31:0] ra, rb;
        bit          stray;
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] m;
        logic [31:0] ra, rb;
        bit          stray;
        repeat (3) @(negedge clk);
        check("reset_outputs", {result[60:0], ready, busy, div_zero}, 64'd0);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b0, 1'b1);
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0);
        run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, 1'b1);
        run_op(32'h8000_0005, 32'h0000_0000, 1'b1, {32'h8000_0005, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h0000_0001}, 1'b0, 1'b0);
        run_op(32'd5, 32'd10, 1'b0, {32'h0000_0005, 32'h0000_0000}, 1'b0, 1'b0);
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 1'b0, 1'b0);

        // Annul at CALC cycle 10 (or the last CALC cycle for short radices).
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat ((LAT - 2 < 10) ? LAT - 3 : 10) @(negedge clk);
        check("busy_before_annul", 64'(busy), 64'd1);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("busy_after_annul", 64'(busy), 64'd0);
        stray = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (ready) stray = 1'b1;
        end
        check("annul_no_ready", 64'(stray), 64'd0);
        run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b0, 1'b1);

        // Asynchronous reset between edges mid-CALC.
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        check("busy_before_rst", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {result[60:0], ready, busy, div_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (ready || busy) stray = 1'b1;
        end
        check("rst_idle", 64'(stray), 64'd0);
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0);

        // Random operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (i % 4 == 1) rb = 32'(-$signed(32'($urandom_range(1, 1000))));
            m = model(ra, rb, i[0]);
            run_op(ra, rb, i[0], m[63:0], m[64], 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parameterised iterative restoring divider for the EX stage (DIV/DIVU).
- Successor to the fixed 32-bit, 1-bit-per-cycle divider.
- Generalised in operand width and in quotient bits retired per cycle (radix 2^BITS_PER_CYCLE).
- Adds three things the old divider lacks:
  - a divide-by-zero flag with defined results;
  - a busy indication;
  - an asynchronous reset.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, quotient bits produced per CALC cycle. Legal values: 1, 2, 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at start.
- start_i  in  1  level request; must stay high until the result is consumed.
- annul_i  in  1  cancel (flush); aborts any operation in progress.
- opdata1_i  in  WIDTH  dividend. Sampled at start.
- opdata2_i  in  WIDTH  divisor. Sampled at start.
- result_o  out  2*WIDTH  {remainder, quotient}: high half = remainder (HI), low half = quotient (LO).
- ready_o  out  1  result valid.
- busy_o  out  1  operation in progress (CALC or FIX state).
- div_zero_o  out  1  result is from a divide-by-zero; valid while ready_o is high.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; iteration counter = 0;
  - result_o = 0, ready_o = 0, busy_o = 0, div_zero_o = 0;
  - internal registers cleared.
- States: IDLE, CALC, FIX, DONE. busy_o = 1 in CALC and FIX.
- IDLE:
  - outputs held at 0.
  - If start_i=1 and annul_i=0, at the edge:
    - latch signed_div_i and the operand signs;
    - latch magnitudes (two's-complement negate if signed and MSB=1);
    - counter = 0.
    - If opdata2_i == 0: go to DONE with div_zero set.
    - Otherwise: go to CALC.
  - If start_i=1 and annul_i=1: no action; stay in IDLE.
- CALC:
  - Each cycle retires BITS_PER_CYCLE quotient bits, MSB first, by repeated trial subtraction of the divisor magnitude from the partial remainder (WIDTH+1-bit compare).
  - After WIDTH/BITS_PER_CYCLE cycles, go to FIX.
  - annul_i=1 in any CALC cycle: go to IDLE at that edge; no result is produced and ready_o stays 0.
- FIX (1 cycle), signed mode only:
  - negate the quotient if sign(dividend) XOR sign(divisor);
  - negate the remainder if sign(dividend) = 1.
  - The remainder always takes the sign of the dividend.
  - annul_i=1: go to IDLE.
  - Otherwise: go to DONE.
- DONE:
  - result_o is registered; ready_o = 1 from the first DONE cycle.
  - Result is held while start_i=1; annul_i is ignored in DONE.
  - When start_i=0: at the edge go to IDLE; result_o, ready_o and div_zero_o return to 0.
- Divide by zero:
  - quotient = all ones; remainder = opdata1_i as presented (unmodified); div_zero_o = 1.
  - ready_o rises 1 cycle after the start edge.
- Overflow (signed MIN / -1): quotient = MIN (e.g. 0x80000000), remainder = 0. No flag.
- Latency: ready_o goes high WIDTH/BITS_PER_CYCLE + 2 edges after the start-sampling edge.
  - 34 for the defaults; 10 for WIDTH=32, BITS_PER_CYCLE=4.
- Input stability: operand or mode changes after the start edge have no effect on the result.
- Back-to-back operation: a new start is accepted only from IDLE, so at least 1 cycle with start_i=0 is needed between operations.

Test Plan:
- Unsigned 100 / 7 (defaults): start held high → ready_o=1 exactly 34 cycles after the start edge; result_o = {0x00000002, 0x0000000E}; div_zero_o=0; busy_o=1 for cycles 1–33.
- Signed -7 / 2 (opdata1=0xFFFFFFF9, opdata2=0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 0x00000010 → quotient 0x0FFFFFFF, remainder 0xF.
- Divide by zero, 0x12345678 / 0 → ready_o after 1 cycle, div_zero_o=1, result_o = {0x12345678, 0xFFFFFFFF}. Dropping start_i clears all three outputs next edge.
- annul_i pulsed at CALC cycle 10 → IDLE; ready_o never rises. A fresh 100 / 7 then completes correctly in 34 cycles.
- Reset and parameter sweep:
  - assert rst asynchronously mid-CALC (between edges) → all outputs 0 immediately, state IDLE;
  - repeat the vectors above with BITS_PER_CYCLE=2 (latency 18) and BITS_PER_CYCLE=4 (latency 10);
  - repeat the vectors above with WIDTH=16 (latency 18 at BITS_PER_CYCLE=1);
  - run random signed and unsigned operands against a reference model.
